// File: rtl/logic_capture_rle_pkg.sv
// Shared constants, state encoding and word-packing helpers for the capture RLE packer.
package logic_capture_pkg;

    localparam logic [1:0]  CAP_WIDTH_32   = 2'd0;
    localparam logic [1:0]  CAP_WIDTH_16   = 2'd1;
    localparam logic [1:0]  CAP_WIDTH_8    = 2'd2;

    localparam logic [23:0] RLE_CNT_MAX_8  = 24'hFFFFFF;
    localparam logic [15:0] RLE_CNT_MAX_16 = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } cap_state_t;

    // Bits of the sample that belong to the active channel group
    function automatic logic [31:0] cap_mask(input logic [1:0] width);
        case (width)
            CAP_WIDTH_8:  cap_mask = 32'h0000_00FF;
            CAP_WIDTH_16: cap_mask = 32'h0000_FFFF;
            default:      cap_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Build an output word: count in the upper bits, data in the lower bits
    function automatic logic [31:0] cap_pack(input logic [1:0]  width,
                                             input logic [23:0] cnt,
                                             input logic [31:0] data);
        case (width)
            CAP_WIDTH_8:  cap_pack = {cnt[23:0], data[7:0]};
            CAP_WIDTH_16: cap_pack = {cnt[15:0], data[15:0]};
            default:      cap_pack = data;
        endcase
    endfunction

endpackage

// File: rtl/logic_capture_rle_out_reg.sv
// Single-entry output holding register; word stays stable until the sink accepts it.
module logic_capture_rle_out_reg (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_tready,
    output logic        o_tvalid,
    output logic [31:0] o_tdata,
    output logic        o_out_free
);

    logic        r_tvalid;
    logic [31:0] r_tdata;

    assign o_out_free = !r_tvalid || i_tready;
    assign o_tvalid   = r_tvalid;
    assign o_tdata    = r_tdata;

    // Load only arrives when the slot is free, so load takes priority over drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
        end else if (i_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= i_data;
        end else if (i_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_capture_rle.sv
// Run-length encoder/packer for the capture stream.
// Define LOGIC_CAPTURE_RLE_EN to collapse repeated 8/16ch samples into {count,data}
// words; without it every sample becomes its own word with count 0.
module logic_capture_rle
    import logic_capture_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        flush_i,
    input  logic [1:0]  cfg_width_i,
    input  logic        input_valid_i,
    input  logic [31:0] input_data_i,
    output logic        outport_tvalid_o,
    output logic [31:0] outport_tdata_o,
    input  logic        outport_tready_i,
    output logic        status_overflow_o,
    output logic        status_idle_o
);

    cap_state_t  r_state, w_state_nxt;
    logic        r_en_q;
    logic [1:0]  r_cfg;
    logic        r_run_valid, w_run_valid_nxt;
    logic [23:0] r_run_cnt, w_run_cnt_nxt;
    logic [31:0] r_run_data, w_run_data_nxt;
    logic        r_overflow;
    logic        w_en_rise, w_out_free, w_emit, w_drop, w_tvalid;
    logic [31:0] w_emit_word, w_samp;

    assign w_en_rise = enable_i && !r_en_q;
    assign w_samp    = input_data_i & cap_mask(r_cfg);

`ifdef LOGIC_CAPTURE_RLE_EN
    logic [23:0] w_cnt_max;
    logic        w_match;
    assign w_cnt_max = (r_cfg == CAP_WIDTH_8) ? RLE_CNT_MAX_8 : {8'h00, RLE_CNT_MAX_16};
    assign w_match   = (w_samp == r_run_data);
`endif

    // Next state, run update and emit/drop decisions.
    // In RUN, enable_i was high on the previous cycle, so a sample on the cycle
    // enable_i falls still belongs to the run before it is flushed.
    always_comb begin
        w_state_nxt     = r_state;
        w_run_valid_nxt = r_run_valid;
        w_run_cnt_nxt   = r_run_cnt;
        w_run_data_nxt  = r_run_data;
        w_emit          = 1'b0;
        w_emit_word     = '0;
        w_drop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en_rise) begin
                    w_state_nxt     = RUN;
                    w_run_valid_nxt = 1'b0;
                    w_run_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (input_valid_i) begin
`ifdef LOGIC_CAPTURE_RLE_EN
                    if (r_cfg == CAP_WIDTH_32) begin
                        if (w_out_free) begin
                            w_emit      = 1'b1;
                            w_emit_word = w_samp;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end else if (!r_run_valid) begin
                        w_run_valid_nxt = 1'b1;
                        w_run_data_nxt  = w_samp;
                        w_run_cnt_nxt   = '0;
                    end else if (w_match && (r_run_cnt != w_cnt_max)) begin
                        w_run_cnt_nxt = r_run_cnt + 24'd1;
                    end else if (w_out_free) begin
                        w_emit         = 1'b1;
                        w_emit_word    = cap_pack(r_cfg, r_run_cnt, r_run_data);
                        w_run_data_nxt = w_samp;
                        w_run_cnt_nxt  = '0;
                    end else begin
                        w_drop = 1'b1;
                    end
`else
                    if (w_out_free) begin
                        w_emit      = 1'b1;
                        w_emit_word = cap_pack(r_cfg, 24'h0, w_samp);
                    end else begin
                        w_drop = 1'b1;
                    end
`endif
                end
                if (flush_i || !enable_i)
                    w_state_nxt = FLUSH;
            end
            FLUSH: begin
                if (input_valid_i && enable_i)
                    w_drop = 1'b1;
                if (!r_run_valid) begin
                    w_state_nxt = enable_i ? RUN : IDLE;
                end else if (w_out_free) begin
                    w_emit          = 1'b1;
                    w_emit_word     = cap_pack(r_cfg, r_run_cnt, r_run_data);
                    w_run_valid_nxt = 1'b0;
                    w_run_cnt_nxt   = '0;
                    w_state_nxt     = enable_i ? RUN : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, open run, enable edge detect and width latch (width only follows input in IDLE)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_en_q      <= 1'b0;
            r_cfg       <= CAP_WIDTH_32;
            r_run_valid <= 1'b0;
            r_run_cnt   <= '0;
            r_run_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_en_q      <= enable_i;
            r_run_valid <= w_run_valid_nxt;
            r_run_cnt   <= w_run_cnt_nxt;
            r_run_data  <= w_run_data_nxt;
            if (r_state == IDLE)
                r_cfg <= (cfg_width_i == 2'd3) ? CAP_WIDTH_32 : cfg_width_i;
        end
    end

    // Sticky overflow; a fresh enable starts a clean capture
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_overflow <= 1'b0;
        else if (w_en_rise)
            r_overflow <= 1'b0;
        else if (w_drop)
            r_overflow <= 1'b1;
    end

    logic_capture_rle_out_reg u_out_reg (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (w_emit),
        .i_data     (w_emit_word),
        .i_tready   (outport_tready_i),
        .o_tvalid   (w_tvalid),
        .o_tdata    (outport_tdata_o),
        .o_out_free (w_out_free)
    );

    assign outport_tvalid_o  = w_tvalid;
    assign status_overflow_o = r_overflow;
    assign status_idle_o     = !r_run_valid && !w_tvalid;

endmodule

// File: tb/tb_logic_capture_rle.sv
// Directed bench for logic_capture_rle; expectations follow LOGIC_CAPTURE_RLE_EN.
module tb_logic_capture_rle;

    logic        clk_i = 1'b0;
    logic        rst_i, enable_i, flush_i, input_valid_i, outport_tready_i;
    logic [1:0]  cfg_width_i;
    logic [31:0] input_data_i;
    logic        outport_tvalid_o, status_overflow_o, status_idle_o;
    logic [31:0] outport_tdata_o;

    int n_cmp = 0;
    int n_err = 0;

    logic_capture_rle dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .enable_i          (enable_i),
        .flush_i           (flush_i),
        .cfg_width_i       (cfg_width_i),
        .input_valid_i     (input_valid_i),
        .input_data_i      (input_data_i),
        .outport_tvalid_o  (outport_tvalid_o),
        .outport_tdata_o   (outport_tdata_o),
        .outport_tready_i  (outport_tready_i),
        .status_overflow_o (status_overflow_o),
        .status_idle_o     (status_idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        input_valid_i = 1'b1;
        input_data_i  = d;
        tick();
        input_valid_i = 1'b0;
    endtask

    task automatic go_idle();
        input_valid_i = 1'b0;
        flush_i       = 1'b0;
        enable_i      = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; flush_i = 1'b0; input_valid_i = 1'b0;
        input_data_i = '0; cfg_width_i = 2'd0; outport_tready_i = 1'b1;
        tick(); tick();
        chk("rst_tvalid", {31'b0, outport_tvalid_o}, 32'd0);
        chk("rst_tdata", outport_tdata_o, 32'd0);
        chk("rst_ovf", {31'b0, status_overflow_o}, 32'd0);
        chk("rst_idle", {31'b0, status_idle_o}, 32'd1);
        rst_i = 1'b0;
        tick();

`ifdef LOGIC_CAPTURE_RLE_EN
        // 8ch: 5x A5 then 3C, then flush
        cfg_width_i = 2'd2; enable_i = 1'b1; tick();
        for (int i = 0; i < 5; i++) send(32'h1234_56A5);
        chk("r8_hold_tvalid", {31'b0, outport_tvalid_o}, 32'd0);
        chk("r8_hold_idle", {31'b0, status_idle_o}, 32'd0);
        send(32'h0000_003C);
        chk("r8_w0_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        chk("r8_w0_tdata", outport_tdata_o, 32'h0000_04A5);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        chk("r8_flush_drain", {31'b0, outport_tvalid_o}, 32'd0);
        tick();
        chk("r8_w1_tdata", outport_tdata_o, 32'h0000_003C);
        chk("r8_w1_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        tick();
        chk("r8_idle_after", {31'b0, status_idle_o}, 32'd1);

        // enable falls together with the 4th 0x77
        for (int i = 0; i < 3; i++) send(32'h0000_0077);
        enable_i = 1'b0; send(32'h0000_0077);
        tick();
        chk("efall_tdata", outport_tdata_o, 32'h0000_0377);
        chk("efall_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        tick();
        chk("efall_idle", {31'b0, status_idle_o}, 32'd1);
        send(32'h0000_0099);
        chk("efall_no_accept_tvalid", {31'b0, outport_tvalid_o}, 32'd0);
        chk("efall_no_accept_idle", {31'b0, status_idle_o}, 32'd1);

        // backpressure, 8ch
        cfg_width_i = 2'd2; enable_i = 1'b1; outport_tready_i = 1'b0; tick();
        send(32'h11); send(32'h22);
        chk("bp_w0_tdata", outport_tdata_o, 32'h0000_0011);
        send(32'h33);
        chk("bp_ovf", {31'b0, status_overflow_o}, 32'd1);
        chk("bp_hold_tdata", outport_tdata_o, 32'h0000_0011);
        enable_i = 1'b0; tick(); tick();
        chk("bp_stall_tdata", outport_tdata_o, 32'h0000_0011);
        chk("bp_stall_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        outport_tready_i = 1'b1; tick();
        chk("bp_w1_tdata", outport_tdata_o, 32'h0000_0022);
        chk("bp_ovf_sticky", {31'b0, status_overflow_o}, 32'd1);
        tick();
        chk("bp_drained_idle", {31'b0, status_idle_o}, 32'd1);
        chk("bp_ovf_sticky2", {31'b0, status_overflow_o}, 32'd1);
        enable_i = 1'b1; tick();
        chk("bp_ovf_clear", {31'b0, status_overflow_o}, 32'd0);

        // 16ch saturation: 65537x 0x1234
        go_idle();
        cfg_width_i = 2'd1; enable_i = 1'b1; tick();
        input_valid_i = 1'b1; input_data_i = 32'hFFFF_1234;
        for (int i = 0; i < 65536; i++) tick();
        chk("sat_no_word_yet", {31'b0, outport_tvalid_o}, 32'd0);
        tick();
        input_valid_i = 1'b0;
        chk("sat_w0_tdata", outport_tdata_o, 32'hFFFF_1234);
        chk("sat_w0_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        flush_i = 1'b1; tick(); flush_i = 1'b0; tick();
        chk("sat_w1_tdata", outport_tdata_o, 32'h0000_1234);
        tick();
`else
        // 8ch pass-through: each sample is its own word
        cfg_width_i = 2'd2; enable_i = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            send(32'h1234_56A5);
            chk("p8_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
            chk("p8_tdata", outport_tdata_o, 32'h0000_00A5);
        end
        tick();
        chk("p8_drain_tvalid", {31'b0, outport_tvalid_o}, 32'd0);
        chk("p8_idle", {31'b0, status_idle_o}, 32'd1);
        flush_i = 1'b1; tick(); flush_i = 1'b0; tick();
        send(32'h0000_003C);
        chk("p8_after_flush_tdata", outport_tdata_o, 32'h0000_003C);
        chk("p8_after_flush_tvalid", {31'b0, outport_tvalid_o}, 32'd1);

        // backpressure, 16ch
        go_idle();
        cfg_width_i = 2'd1; enable_i = 1'b1; outport_tready_i = 1'b0; tick();
        send(32'hABCD_1111);
        chk("pbp_w0_tdata", outport_tdata_o, 32'h0000_1111);
        send(32'h0000_2222);
        chk("pbp_ovf", {31'b0, status_overflow_o}, 32'd1);
        chk("pbp_hold_tdata", outport_tdata_o, 32'h0000_1111);
        enable_i = 1'b0; tick(); tick();
        outport_tready_i = 1'b1; tick();
        chk("pbp_drained", {31'b0, outport_tvalid_o}, 32'd0);
        chk("pbp_ovf_sticky", {31'b0, status_overflow_o}, 32'd1);
        enable_i = 1'b1; tick();
        chk("pbp_ovf_clear", {31'b0, status_overflow_o}, 32'd0);
`endif

        // 32ch raw, width change mid-run is ignored
        go_idle();
        cfg_width_i = 2'd0; enable_i = 1'b1; tick();
        send(32'h0000_0001);
        chk("r32_w0", outport_tdata_o, 32'h0000_0001);
        send(32'h0000_0001);
        chk("r32_w1", outport_tdata_o, 32'h0000_0001);
        chk("r32_w1_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        cfg_width_i = 2'd2;
        send(32'hDEAD_BEEF);
        chk("r32_w2", outport_tdata_o, 32'hDEAD_BEEF);
        tick();
        chk("r32_drain_tvalid", {31'b0, outport_tvalid_o}, 32'd0);
        chk("r32_idle", {31'b0, status_idle_o}, 32'd1);

        // reset with an open run and a held word
        go_idle();
        cfg_width_i = 2'd1; enable_i = 1'b1; outport_tready_i = 1'b0; tick();
        send(32'h11);
        for (int i = 0; i < 10; i++) send(32'h55);
        chk("mr_pre_tvalid", {31'b0, outport_tvalid_o}, 32'd1);
        rst_i = 1'b1; tick();
        chk("mr_tvalid", {31'b0, outport_tvalid_o}, 32'd0);
        chk("mr_tdata", outport_tdata_o, 32'd0);
        chk("mr_ovf", {31'b0, status_overflow_o}, 32'd0);
        chk("mr_idle", {31'b0, status_idle_o}, 32'd1);
        rst_i = 1'b0; enable_i = 1'b0; outport_tready_i = 1'b1;
        tick(); tick(); tick();
        chk("mr_no_word", {31'b0, outport_tvalid_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
